// File: rtl/aes_ctrl_pkg.sv
// Shared types and defaults for the AES round sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: aes_ctrl_state_t (sequencer state), default round count and
// round-index width used as parameter defaults by the controller and its bus.
package aes_ctrl_pkg;

    // Default AES-128 round count; 12 and 14 are the other legal values.
    localparam int AES_NR_DEFAULT = 10;
    // Round/key index width; must satisfy 2**RW > NR.
    localparam int AES_RW_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } aes_ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Control bus between the AES round sequencer and its datapath.
// Latency: n/a (wires only).
// Backpressure: stall from the datapath freezes the sequencer.
// master: sequencer side (drives enables, selects, indices, busy/done).
// slave : datapath/requester side (drives start, decrypt, stall).
interface aes_round_ctrl_if
    import aes_ctrl_pkg::*;
#(
    parameter int RW = AES_RW_DEFAULT
);
    logic          start;
    logic          decrypt;
    logic          stall;
    logic          busy;
    logic          done;
    logic          state_en;
    logic          key_en;
    logic          sel_init;
    logic          sel_final;
    logic [RW-1:0] round_idx;
    logic [RW-1:0] key_idx;

    modport master (
        input  start, decrypt, stall,
        output busy, done, state_en, key_en, sel_init, sel_final,
               round_idx, key_idx
    );

    modport slave (
        output start, decrypt, stall,
        input  busy, done, state_en, key_en, sel_init, sel_final,
               round_idx, key_idx
    );
endinterface

// File: rtl/register.sv
// Generic N-bit load-enable register with asynchronous active-high clear.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; holds q while en is low.
// Ports: clk, rst (async clear to 0), en (load), d (next value), q (value).
module register #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps IDLE -> INIT -> ROUND x(NR-1) -> FINAL -> DONE.
// Latency: start accepted at edge k gives done for the cycle after edge k+NR+1.
// Backpressure: stall=1 freezes state and round counter and drops both enables.
// Ports: clk, rst (async, active-high), bus (aes_round_ctrl_if.master):
//   start/decrypt/stall in; busy, done, state_en, key_en, sel_init,
//   sel_final, round_idx, key_idx out.
// Build option AES_ROUND_CTRL_DECRYPT_EN: when defined, decrypt is captured
// with start and key_idx counts down (NR - round_idx) for decrypt blocks;
// otherwise decrypt is ignored and key_idx always equals round_idx.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR = AES_NR_DEFAULT,
    parameter int RW = AES_RW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    aes_round_ctrl_if.master   bus
);

    localparam logic [RW-1:0] NR_W   = RW'(NR);
    localparam logic [RW-1:0] LAST_R = RW'(NR - 1);

    aes_ctrl_state_t state_q;
    aes_ctrl_state_t state_d;

    logic [RW-1:0] round_idx;
    logic [RW-1:0] cnt_d;
    logic          cnt_en;
    logic          active;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. The only input seen by the outputs is
    // stall, which gates the write enables combinationally.
    always_comb begin
        state_d       = state_q;
        active        = 1'b0;
        cnt_en        = 1'b0;
        cnt_d         = round_idx + 1'b1;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.sel_init  = 1'b0;
        bus.sel_final = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                active       = 1'b1;
                bus.sel_init = 1'b1;
                cnt_en       = !bus.stall;
                if (!bus.stall) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                active = 1'b1;
                cnt_en = !bus.stall;
                // The increment out of the last middle round lands on NR,
                // which is the index the final round runs with.
                if (!bus.stall && (round_idx == LAST_R)) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                active        = 1'b1;
                bus.sel_final = 1'b1;
                if (!bus.stall) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                // round_idx keeps NR while done is shown, clears on the way out.
                cnt_en   = 1'b1;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bus.busy = active;
    end

    assign bus.state_en  = active && !bus.stall;
    assign bus.key_en    = active && !bus.stall;
    assign bus.round_idx = round_idx;

    register #(
        .N (RW)
    ) u_round_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .d   (cnt_d),
        .q   (round_idx)
    );

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    // Block mode, captured only when a start is accepted in IDLE.
    logic mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            mode_q <= bus.decrypt;
        end
    end

    // Decryption consumes the key schedule in reverse order.
    assign bus.key_idx = mode_q ? (NR_W - round_idx) : round_idx;
`else
    logic unused_decrypt;
    logic [RW-1:0] unused_nr;

    assign unused_decrypt = bus.decrypt;
    assign unused_nr      = NR_W;
    assign bus.key_idx    = round_idx;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: per-cycle expected outputs are queued by the
// stimulus thread from a block-position model and checked by a monitor.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    aes_round_ctrl_if #(.RW(RW)) bus ();

    aes_round_ctrl #(
        .NR (NR),
        .RW (RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          state_en;
        logic          key_en;
        logic          sel_init;
        logic          sel_final;
        logic [RW-1:0] round_idx;
        logic [RW-1:0] key_idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference: is a block in flight, which step of it (0 = key add,
    // NR = last round, NR+1 = done cycle), and which key order it uses.
    bit m_active = 1'b0;
    int m_p      = 0;
    bit m_dec    = 1'b0;

    function automatic exp_t model_out(bit rs, bit sl);
        exp_t e;
        int   r;
        e = '0;
        r = 0;
        if (!rs) begin
            if (m_active) begin
                r           = (m_p > NR) ? NR : m_p;
                e.busy      = (m_p <= NR);
                e.done      = (m_p == NR + 1);
                e.state_en  = e.busy && !sl;
                e.key_en    = e.busy && !sl;
                e.sel_init  = (m_p == 0);
                e.sel_final = (m_p == NR);
            end
            e.round_idx = RW'(r);
            e.key_idx   = m_dec ? RW'(NR - r) : RW'(r);
        end
        return e;
    endfunction

    task automatic cycle(input bit st, input bit dc, input bit sl, input bit rs);
        @(posedge clk);
        #1;
        bus.start   = st;
        bus.decrypt = dc;
        bus.stall   = sl;
        rst         = rs;
        cyc++;
        if (rs) begin
            m_active = 1'b0;
            m_p      = 0;
            m_dec    = 1'b0;
        end
        exp_q.push_back(model_out(rs, sl));
        if (rs) begin
            // stays idle across the edge
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_p      = 0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
                m_dec    = dc;
`endif
            end
        end else if (m_p == NR + 1) begin
            m_active = 1'b0;
            m_p      = 0;
        end else if (!sl) begin
            m_p++;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
        end
    endtask

    // Monitor: compares the DUT against the queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("busy",      int'(bus.busy),      int'(e.busy));
                chk("done",      int'(bus.done),      int'(e.done));
                chk("state_en",  int'(bus.state_en),  int'(e.state_en));
                chk("key_en",    int'(bus.key_en),    int'(e.key_en));
                chk("sel_init",  int'(bus.sel_init),  int'(e.sel_init));
                chk("sel_final", int'(bus.sel_final), int'(e.sel_final));
                chk("round_idx", int'(bus.round_idx), int'(e.round_idx));
                chk("key_idx",   int'(bus.key_idx),   int'(e.key_idx));
            end
        end
    end

    initial begin
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        bus.stall   = 1'b0;

        // Reset values, with inputs wiggling under reset.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Unstalled encrypt block, plus idle tail.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NR + 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Stall for three cycles at round 5, also stall in DONE/IDLE.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        while (!(m_active && m_p == 5)) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        while (!(m_active && m_p == NR + 1)) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Decrypt block; key order reverses only when the option is built in.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NR + 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Abort at round 7, then a full block must follow.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        while (!(m_active && m_p == 7)) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NR + 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // start held high: back-to-back blocks, mode flipping mid-block.
        for (int i = 0; i < 3 * (NR + 3); i++) cycle(1'b1, i[0], 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(2) == 0), 1'($urandom),
                  ($urandom_range(3) == 0), ($urandom_range(199) == 0));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds (legal 10, 12, 14).
REQ-002 SHALL have parameter RW, default 4, width of round/key index outputs (2^RW > NR).
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request one block operation; sampled only in IDLE.
REQ-006 SHALL have port decrypt  input  1  operation mode, captured with accepted start (1 = decrypt).
REQ-007 SHALL have port stall  input  1  datapath not ready; freezes sequencing.
REQ-008 SHALL have port busy  output  1  high in INIT, ROUND and FINAL.
REQ-009 SHALL have port done  output  1  one-cycle pulse, high in DONE.
REQ-010 SHALL have port state_en  output  1  write enable for the state register.
REQ-011 SHALL have port key_en  output  1  write enable for the round-key register.
REQ-012 SHALL have port sel_init  output  1  selects initial AddRoundKey path (round 0).
REQ-013 SHALL have port sel_final  output  1  selects final-round path (no MixColumns).
REQ-014 SHALL have port round_idx  output  RW  current round number.
REQ-015 SHALL have port key_idx  output  RW  round-key index to fetch.

Function
REQ-016 SHALL implement Moore FSM states IDLE, INIT, ROUND, FINAL, DONE; all outputs decoded from registered state/counter only.
REQ-017 SHALL transition IDLE->INIT on start=1; start=0 holds IDLE; captured mode register loads decrypt at the same edge.
REQ-018 SHALL transition INIT->ROUND (round_idx 0->1), ROUND->ROUND while round_idx<NR-1 (increment), ROUND->FINAL when round_idx=NR-1 (to NR), FINAL->DONE, DONE->IDLE, each only when stall=0.
REQ-019 SHALL, when stall=1 in INIT/ROUND/FINAL, hold state and round_idx and drive state_en=key_en=0; busy stays 1.
REQ-020 SHALL drive state_en=key_en=1 in INIT/ROUND/FINAL when stall=0, else 0.
REQ-021 SHALL drive sel_init=1 only in INIT; sel_final=1 only in FINAL.
REQ-022 SHALL give unstalled latency: start accepted at edge k -> done high for exactly the cycle after edge k+NR+1, i.e. NR+1 busy cycles.
REQ-023 SHALL ignore start and decrypt outside IDLE (including the DONE cycle); no queuing.
REQ-024 SHALL drive key_idx=round_idx in encrypt mode.
REQ-025 SHALL hold round_idx at last value in DONE and reset it to 0 on DONE->IDLE.
REQ-026 SHALL let stall have no effect in IDLE and DONE.

Reset
REQ-027 SHALL, on rst=1, enter IDLE immediately regardless of state, including mid-operation; operation aborted, no done pulse.
REQ-028 SHALL reset values: busy=0, done=0, state_en=0, key_en=0, sel_init=0, sel_final=0, round_idx=0, key_idx=0, mode=encrypt.

Configuration
REQ-029 SHALL, with AES_ROUND_CTRL_DECRYPT_EN defined, drive key_idx=NR-round_idx when captured mode is decrypt.
REQ-030 SHALL, without AES_ROUND_CTRL_DECRYPT_EN, keep the decrypt port, ignore it, force mode to encrypt, and omit the mode register.

Structure
REQ-031 SHALL place the state enum type (aes_ctrl_state_t) and default NR/RW constants in shared package aes_ctrl_pkg.
REQ-032 SHALL build the round counter from the team's existing N-bit register primitive (register, N=RW), with en tied to the counter update condition; no other sub-modules.

Verification
REQ-033 SHALL cover encrypt, NR=10, stall=0: start at cycle 0 -> busy cycles 1-11, round_idx 0..10, sel_init at cycle 1, sel_final at cycle 11, done at cycle 12 only.
REQ-034 SHALL cover stall=1 for 3 cycles at round_idx=5 -> round_idx holds 5, enables 0, done delayed to cycle 15.
REQ-035 SHALL cover decrypt with macro defined -> key_idx 10,9,..,0 while round_idx 0..10; without macro -> key_idx equals round_idx.
REQ-036 SHALL cover rst asserted at round_idx=7 -> all outputs at reset values same cycle, no done; next start runs a full 12-cycle sequence.
REQ-037 SHALL cover start held high continuously -> back-to-back operations, start during busy/DONE ignored, new INIT the cycle after returning to IDLE.
